// File: rtl/pong_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : pong_round_controller
// Purpose  : Round/score sequencer for the Pong datapath: serve delay, point
//            counting, pause and game-over with winner flag.
// Revision : 1.0  initial release
// ============================================================================
module pong_round_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       point_p1,
    input  logic       point_p2,
    output logic       reset_to_start,
    output logic       stand,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       score_event,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_serve_delay = CNT_W'(SERVE_DELAY);
    localparam logic [3:0]       c_win_score   = 4'(WIN_SCORE);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       r_score_p1;
    logic [3:0]       r_score_p2;
    logic [3:0]       w_score_p1_next;
    logic [3:0]       w_score_p2_next;
    logic [1:0]       r_winner;
    logic [1:0]       w_winner_next;
    logic             w_score_event_next;
    logic             w_restart;
    logic             r_reset_to_start;
    logic             r_stand;
    logic             r_score_event;
    logic             r_game_over;

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_score_p1_next    = r_score_p1;
        w_score_p2_next    = r_score_p2;
        w_winner_next      = r_winner;
        w_score_event_next = 1'b0;
        w_restart          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_btn) w_restart = 1'b1;
            end
            ST_SERVE: begin
                if (start_btn)
                    w_restart = 1'b1;
                else if (r_cnt == '0)
                    w_state_next = ST_PLAY;
                else if (frame_tick)
                    w_cnt_next = r_cnt - CNT_W'(1);
            end
            ST_PLAY: begin
                if (start_btn) begin
                    w_restart = 1'b1;
                end else if (point_p1 && point_p2) begin
                    // Simultaneous points cancel out and the rally is re-served.
                    w_state_next = ST_SERVE;
                    w_cnt_next   = c_serve_delay;
                end else if (point_p1) begin
                    if (r_score_p1 < c_win_score) w_score_p1_next = r_score_p1 + 4'd1;
                    w_score_event_next = 1'b1;
                    w_state_next       = ST_POINT;
                end else if (point_p2) begin
                    if (r_score_p2 < c_win_score) w_score_p2_next = r_score_p2 + 4'd1;
                    w_score_event_next = 1'b1;
                    w_state_next       = ST_POINT;
                end else if (pause_btn) begin
                    w_state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (start_btn)
                    w_restart = 1'b1;
                else if (pause_btn)
                    w_state_next = ST_PLAY;
            end
            ST_POINT: begin
                if (r_score_p1 == c_win_score) begin
                    w_winner_next = 2'b01;
                    w_state_next  = ST_GAME_OVER;
                end else if (r_score_p2 == c_win_score) begin
                    w_winner_next = 2'b10;
                    w_state_next  = ST_GAME_OVER;
                end else begin
                    w_state_next = ST_SERVE;
                    w_cnt_next   = c_serve_delay;
                end
            end
            ST_GAME_OVER: begin
                if (start_btn) w_restart = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_restart) begin
            w_state_next    = ST_SERVE;
            w_cnt_next      = c_serve_delay;
            w_score_p1_next = 4'd0;
            w_score_p2_next = 4'd0;
            w_winner_next   = 2'b00;
        end
    end

    // Decoded outputs are registered from the next state so they align with state_dbg.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_score_p1       <= 4'd0;
            r_score_p2       <= 4'd0;
            r_winner         <= 2'b00;
            r_score_event    <= 1'b0;
            r_game_over      <= 1'b0;
            r_reset_to_start <= 1'b1;
            r_stand          <= 1'b1;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_score_p1       <= w_score_p1_next;
            r_score_p2       <= w_score_p2_next;
            r_winner         <= w_winner_next;
            r_score_event    <= w_score_event_next;
            r_game_over      <= (w_state_next == ST_GAME_OVER);
            r_reset_to_start <= (w_state_next == ST_IDLE) || (w_state_next == ST_SERVE);
            r_stand          <= (w_state_next != ST_PLAY);
        end
    end

    assign reset_to_start = r_reset_to_start;
    assign stand          = r_stand;
    assign score_p1       = r_score_p1;
    assign score_p2       = r_score_p2;
    assign score_event    = r_score_event;
    assign game_over      = r_game_over;
    assign winner         = r_winner;
    assign state_dbg      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_round_controller
// Purpose  : Self-checking bench for pong_round_controller against a
//            behavioural round model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_round_controller;

    localparam int c_win   = 2;
    localparam int c_delay = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       reset_to_start;
    logic       stand;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       score_event;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase codes 0 idle,1 serve,2 play,3 paused,4 point,5 game over.
    logic [2:0] m_phase = 3'd0;
    int         m_left  = 0;
    logic [3:0] m_s1    = 4'd0;
    logic [3:0] m_s2    = 4'd0;
    logic [1:0] m_win   = 2'b00;
    logic       m_ev    = 1'b0;

    logic [16:0] obs;
    assign obs = {state_dbg, reset_to_start, stand, score_p1, score_p2,
                  score_event, game_over, winner};

    pong_round_controller #(
        .WIN_SCORE  (c_win),
        .SERVE_DELAY(c_delay),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start_btn     (start_btn),
        .pause_btn     (pause_btn),
        .point_p1      (point_p1),
        .point_p2      (point_p2),
        .reset_to_start(reset_to_start),
        .stand         (stand),
        .score_p1      (score_p1),
        .score_p2      (score_p2),
        .score_event   (score_event),
        .game_over     (game_over),
        .winner        (winner),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] exp_vec();
        return {m_phase, (m_phase <= 3'd1), (m_phase != 3'd2), m_s1, m_s2,
                m_ev, (m_phase == 3'd5), m_win};
    endfunction

    task automatic new_game();
        m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00;
        m_phase = 3'd1; m_left = c_delay;
    endtask

    task automatic model_update(input logic r, st, pa, p1, p2, ft);
        m_ev = 1'b0;
        if (r) begin
            m_phase = 3'd0; m_left = 0; m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00;
        end else begin
            case (m_phase)
                3'd0: if (st) new_game();
                3'd1: begin
                    if (st) new_game();
                    else if (m_left == 0) m_phase = 3'd2;
                    else if (ft) m_left = m_left - 1;
                end
                3'd2: begin
                    if (st) new_game();
                    else if (p1 && p2) begin m_phase = 3'd1; m_left = c_delay; end
                    else if (p1) begin
                        if (m_s1 < 4'(c_win)) m_s1 = m_s1 + 4'd1;
                        m_ev = 1'b1; m_phase = 3'd4;
                    end else if (p2) begin
                        if (m_s2 < 4'(c_win)) m_s2 = m_s2 + 4'd1;
                        m_ev = 1'b1; m_phase = 3'd4;
                    end else if (pa) m_phase = 3'd3;
                end
                3'd3: begin
                    if (st) new_game();
                    else if (pa) m_phase = 3'd2;
                end
                3'd4: begin
                    if (m_s1 == 4'(c_win)) begin m_win = 2'b01; m_phase = 3'd5; end
                    else if (m_s2 == 4'(c_win)) begin m_win = 2'b10; m_phase = 3'd5; end
                    else begin m_phase = 3'd1; m_left = c_delay; end
                end
                default: if (st) new_game();
            endcase
        end
    endtask

    task automatic step(input logic r, st, pa, p1, p2, ft);
        @(negedge clk);
        reset = r; start_btn = st; pause_btn = pa;
        point_p1 = p1; point_p2 = p2; frame_tick = ft;
        @(posedge clk);
        model_update(r, st, pa, p1, p2, ft);
        #1;
    endtask

    task automatic go_play();
        for (int i = 0; i < 40; i++) begin
            if (state_dbg == 3'd2) break;
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (state_dbg !== 3'd2) begin
            n_errors++;
            $display("FAIL go_play_timeout state=%0d required=2", state_dbg);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL reset_values obs=%h required=%h", obs, {3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_serve();
        int serve_cycles;
        // Frame tick every 4 clocks, checked against the model each cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && state_dbg != 3'd2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i % 4) == 3);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL serve_slow cycle=%0d obs=%h required=%h", i, obs, exp_vec());
            end
        end
        // With a tick every cycle the serve must last exactly 3 ticks + 1 clk.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        serve_cycles = (state_dbg == 3'd1) ? 1 : 0;
        for (int i = 0; i < 20 && state_dbg == 3'd1; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (state_dbg == 3'd1) serve_cycles++;
        end
        n_checks++;
        if (serve_cycles !== c_delay + 1) begin
            n_errors++;
            $display("FAIL serve_length cycles=%0d required=%0d", serve_cycles, c_delay + 1);
        end
        n_checks++;
        if ({state_dbg, stand, reset_to_start} !== {3'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL serve_to_play state=%0d stand=%b rts=%b required 2/0/0", state_dbg, stand, reset_to_start);
        end
    endtask

    task automatic test_point_p2();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== {3'd4, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL point_p2 obs=%h required=%h", obs, {3'd4, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 2'b00});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {3'd1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL point_p2_reserve obs=%h required=%h", obs, {3'd1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_both_points();
        go_play();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== {3'd1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL both_points obs=%h required=%h", obs, {3'd1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_pause();
        go_play();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({state_dbg, stand} !== {3'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL pause_enter state=%0d stand=%b required 3/1", state_dbg, stand);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== {3'd3, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL pause_point_ignored obs=%h required=%h", obs, {3'd3, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00});
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {3'd2, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL pause_resume obs=%h required=%h", obs, {3'd2, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_win();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            go_play();
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (obs !== {3'd5, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 2'b01}) begin
            n_errors++;
            $display("FAIL win_p1 obs=%h required=%h", obs, {3'd5, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 2'b01});
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, i[0], 1'b1);
        n_checks++;
        if (obs !== {3'd5, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 2'b01}) begin
            n_errors++;
            $display("FAIL win_held obs=%h required=%h", obs, {3'd5, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0, 1'b1, 2'b01});
        end
    endtask

    task automatic test_restart_from_game_over();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {3'd1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL restart_game_over obs=%h required=%h", obs, {3'd1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00});
        end
    endtask

    task automatic test_reset_mid_serve();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== {3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin
            n_errors++;
            $display("FAIL reset_mid_serve obs=%h required=%h", obs, {3'd0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00});
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (state_dbg !== 3'd0) begin
            n_errors++;
            $display("FAIL idle_ignores_inputs state=%0d required=0", state_dbg);
        end
    endtask

    task automatic test_random();
        logic r, st, pa, p1, p2, ft;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 255) == 0);
            st = ($urandom_range(0, 63) == 0);
            pa = ($urandom_range(0, 15) == 0);
            p1 = ($urandom_range(0, 7) == 0);
            p2 = ($urandom_range(0, 7) == 0);
            ft = ($urandom_range(0, 1) == 0);
            step(r, st, pa, p1, p2, ft);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cycle=%0d obs=%h required=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point_p2();
        test_both_points();
        test_pause();
        test_win();
        test_restart_from_game_over();
        test_reset_mid_serve();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
